// File: rtl/decode_queue.sv
// Two-wide in-order decode queue between the dual decoders and the schedule unit.
// Circular buffer of decode_s records; accepts 0-2 records per cycle and delivers
// the oldest 1-2 records per request through a registered output stage.

package decode_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] imm;
    } decode_s;

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_flush,

    input  logic    i_dec_dque_valid_0,
    input  logic    i_dec_dque_valid_1,
    input  decode_s i_dec_dque_decode_0,
    input  decode_s i_dec_dque_decode_1,
    output logic    o_dque_dec_ready,

    input  logic    i_sch_dque_request,
    output logic    o_dque_sch_ready,
    output logic    o_dque_sch_ack,
    output decode_s o_dque_sch_decode_0,
    output decode_s o_dque_sch_decode_1
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Keeping two entries of headroom means a 2-wide push can never overflow.
    localparam logic [CntW-1:0] DecReadyMax = CntW'(DEPTH - 2);

    // Storage and pointers
    decode_s           mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    // Registered delivery stage
    logic              ack_q, ack_d;
    decode_s           out0_q, out0_d;
    decode_s           out1_q, out1_d;

    // Push side
    logic              push_ok;
    logic              wr_en_a, wr_en_b;
    logic [PtrW-1:0]   wr_idx_a, wr_idx_b;
    decode_s           wr_data_a, wr_data_b;
    logic [CntW-1:0]   n_push;

    // Pop side
    logic              pop_en;
    logic              pop_two;
    logic [PtrW-1:0]   rd_idx_b;
    logic [CntW-1:0]   n_pop;

    // Ready flags come from the registered count only
    always_comb begin
        o_dque_dec_ready = (count_q <= DecReadyMax);
        o_dque_sch_ready = (count_q != '0);
    end

    // Push decode: the first valid slot always lands at wr_ptr so entries stay compacted
    always_comb begin
        push_ok   = o_dque_dec_ready;
        wr_en_a   = push_ok && (i_dec_dque_valid_0 || i_dec_dque_valid_1);
        wr_en_b   = push_ok && i_dec_dque_valid_0 && i_dec_dque_valid_1;
        wr_idx_a  = wr_ptr_q;
        wr_idx_b  = wr_ptr_q + PtrW'(1);
        wr_data_a = i_dec_dque_valid_0 ? i_dec_dque_decode_0 : i_dec_dque_decode_1;
        wr_data_a.valid = 1'b1;
        wr_data_b = i_dec_dque_decode_1;
        wr_data_b.valid = 1'b1;
        n_push    = CntW'(wr_en_a) + CntW'(wr_en_b);
    end

    // Pop decode: take min(count, 2) of the entries present before this edge
    always_comb begin
        pop_en   = i_sch_dque_request && (count_q != '0);
        pop_two  = (count_q > CntW'(1));
        rd_idx_b = rd_ptr_q + PtrW'(1);
        n_pop    = '0;
        if (pop_en) begin
            n_pop = pop_two ? CntW'(2) : CntW'(1);
        end
    end

    // Next-state for pointers, count and the delivery stage
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(n_push);
        rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
        count_d  = count_q + n_push - n_pop;

        ack_d        = 1'b0;
        out0_d       = out0_q;
        out0_d.valid = 1'b0;
        out1_d       = out1_q;
        out1_d.valid = 1'b0;

        if (pop_en) begin
            ack_d        = 1'b1;
            out0_d       = mem_q[rd_ptr_q];
            out0_d.valid = 1'b1;
            out1_d       = mem_q[rd_idx_b];
            out1_d.valid = pop_two;
        end
    end

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (wr_en_a) begin
            mem_q[wr_idx_a] <= wr_data_a;
        end
        if (wr_en_b) begin
            mem_q[wr_idx_b] <= wr_data_b;
        end
    end

    // Queue state and output stage; flush behaves like reset and beats push/pop
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ack_q        <= 1'b0;
            out0_q.valid <= 1'b0;
            out1_q.valid <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
        end
    end

    // Output drive
    always_comb begin
        o_dque_sch_ack      = ack_q;
        o_dque_sch_decode_0 = out0_q;
        o_dque_sch_decode_1 = out1_q;
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios followed by a random
// phase, all compared against a queue-based reference model.

module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic    i_clk;
    logic    i_rst;
    logic    i_flush;
    logic    i_dec_dque_valid_0;
    logic    i_dec_dque_valid_1;
    decode_s i_dec_dque_decode_0;
    decode_s i_dec_dque_decode_1;
    logic    o_dque_dec_ready;
    logic    i_sch_dque_request;
    logic    o_dque_sch_ready;
    logic    o_dque_sch_ack;
    decode_s o_dque_sch_decode_0;
    decode_s o_dque_sch_decode_1;

    decode_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_flush             (i_flush),
        .i_dec_dque_valid_0  (i_dec_dque_valid_0),
        .i_dec_dque_valid_1  (i_dec_dque_valid_1),
        .i_dec_dque_decode_0 (i_dec_dque_decode_0),
        .i_dec_dque_decode_1 (i_dec_dque_decode_1),
        .o_dque_dec_ready    (o_dque_dec_ready),
        .i_sch_dque_request  (i_sch_dque_request),
        .o_dque_sch_ready    (o_dque_sch_ready),
        .o_dque_sch_ack      (o_dque_sch_ack),
        .o_dque_sch_decode_0 (o_dque_sch_decode_0),
        .o_dque_sch_decode_1 (o_dque_sch_decode_1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: a plain FIFO of records plus the expected output stage
    decode_s mq [$];
    decode_s e0, e1;
    bit      e_ack   = 1'b0;
    bit      e0_known = 1'b0;
    logic [4:0] next_addr = 5'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic decode_s mk(input logic [4:0] rd);
        decode_s r;
        r.valid    = 1'($urandom_range(0, 1));
        r.pc       = $urandom;
        r.opcode   = 7'($urandom);
        r.rd_addr  = rd;
        r.rs1_addr = 5'($urandom);
        r.rs2_addr = 5'($urandom);
        r.imm      = $urandom;
        return r;
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model, compare.
    task automatic step(input bit rst, input bit flush, input bit v0, input bit v1,
                        input bit req, input logic [4:0] a0, input logic [4:0] a1);
        decode_s d0;
        decode_s d1;
        bit      rdy;
        int      n;
        d0 = mk(a0);
        d1 = mk(a1);
        i_rst               = rst;
        i_flush             = flush;
        i_dec_dque_valid_0  = v0;
        i_dec_dque_valid_1  = v1;
        i_dec_dque_decode_0 = d0;
        i_dec_dque_decode_1 = d1;
        i_sch_dque_request  = req;
        @(posedge i_clk);
        #1;
        if (rst || flush) begin
            mq.delete();
            e_ack    = 1'b0;
            e0.valid = 1'b0;
            e1.valid = 1'b0;
        end else begin
            rdy = (mq.size() <= DEPTH - 2);
            if (req && mq.size() != 0) begin
                n        = (mq.size() >= 2) ? 2 : 1;
                e_ack    = 1'b1;
                e0       = mq.pop_front();
                e0_known = 1'b1;
                if (n == 2) e1 = mq.pop_front();
                e1.valid = (n == 2);
            end else begin
                e_ack    = 1'b0;
                e0.valid = 1'b0;
                e1.valid = 1'b0;
            end
            if (rdy) begin
                d0.valid = 1'b1;
                d1.valid = 1'b1;
                if (v0) mq.push_back(d0);
                if (v1) mq.push_back(d1);
            end
        end
        chk("ack", 128'(o_dque_sch_ack), 128'(e_ack));
        chk("out0_valid", 128'(o_dque_sch_decode_0.valid), 128'(e0.valid));
        chk("out1_valid", 128'(o_dque_sch_decode_1.valid), 128'(e1.valid));
        chk("count", 128'(dut.count_q), 128'(mq.size()));
        chk("dec_ready", 128'(o_dque_dec_ready), 128'(mq.size() <= DEPTH - 2));
        chk("sch_ready", 128'(o_dque_sch_ready), 128'(mq.size() != 0));
        if (e0_known) chk("out0_rec", 128'(o_dque_sch_decode_0), 128'(e0));
        if (e1.valid) chk("out1_rec", 128'(o_dque_sch_decode_1), 128'(e1));
    endtask

    task automatic push2(input bit req);
        step(1'b0, 1'b0, 1'b1, 1'b1, req, next_addr, next_addr + 5'd1);
        next_addr = next_addr + 5'd2;
    endtask

    task automatic push1(input bit req);
        step(1'b0, 1'b0, 1'b1, 1'b0, req, next_addr, 5'd0);
        next_addr = next_addr + 5'd1;
    endtask

    task automatic idle(input bit req);
        step(1'b0, 1'b0, 1'b0, 1'b0, req, 5'd0, 5'd0);
    endtask

    initial begin
        i_rst               = 1'b1;
        i_flush             = 1'b0;
        i_dec_dque_valid_0  = 1'b0;
        i_dec_dque_valid_1  = 1'b0;
        i_dec_dque_decode_0 = '0;
        i_dec_dque_decode_1 = '0;
        i_sch_dque_request  = 1'b0;

        // Reset then request on an empty queue
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(1'b1);
        idle(1'b1);

        // Push a pair (5, 6) then pop it
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6);
        idle(1'b1);
        chk("pair_rd0", 128'(o_dque_sch_decode_0.rd_addr), 128'(5));
        chk("pair_rd1", 128'(o_dque_sch_decode_1.rd_addr), 128'(6));
        chk("pair_cnt0", 128'(dut.count_q), 128'(0));

        // Slot-1-only push of rd_addr 9
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd9);
        idle(1'b1);
        chk("single_rd0", 128'(o_dque_sch_decode_0.rd_addr), 128'(9));
        chk("single_v1", 128'(o_dque_sch_decode_1.valid), 128'(0));

        // Fill to DEPTH-1, try an ignored push, then stream across the wrap
        repeat (3) push2(1'b0);
        push1(1'b0);
        chk("full_ready", 128'(o_dque_dec_ready), 128'(0));
        push2(1'b0);
        repeat (10) push2(1'b1);
        repeat (6) idle(1'b1);

        // Simultaneous push 2 / pop 2 at count 6
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (3) push2(1'b0);
        push2(1'b1);
        chk("cnt6", 128'(dut.count_q), 128'(6));
        chk("cnt6_ready", 128'(o_dque_dec_ready), 128'(1));

        // Flush mid-stream at count 5 with request and push in the same cycle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (2) push2(1'b0);
        push1(1'b1);
        push2(1'b0);
        chk("pre_flush_cnt", 128'(dut.count_q), 128'(5));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 5'd21);
        chk("flush_ack", 128'(o_dque_sch_ack), 128'(0));
        chk("flush_cnt", 128'(dut.count_q), 128'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
        idle(1'b1);
        chk("post_flush_rd", 128'(o_dque_sch_decode_0.rd_addr), 128'(3));

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            bit fl, rs, v0, v1, rq;
            rs = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 31) == 0);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            rq = ($urandom_range(0, 2) != 0);
            step(rs, fl, v0, v1, rq, next_addr, next_addr + 5'd1);
            next_addr = next_addr + 5'd2;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Two-wide in-order decode queue sitting between the dual decoders and the schedule unit. Buffers up to `DEPTH` `decode_s` records written by the decoders, 0–2 per cycle. On a schedule-unit request, delivers the oldest one or two records with a registered ack. Flush support discards all buffered instructions on a redirect.

## Interface
- `DEPTH`, 8: number of entries. Power of two, ≥ 4.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_flush`  in  1  discard all contents; same effect as reset on the queue state.
- `i_dec_dque_valid_0`  in  1  decoder slot 0 has an instruction.
- `i_dec_dque_valid_1`  in  1  decoder slot 1 has an instruction (younger than slot 0).
- `i_dec_dque_decode_0`  in  `$bits(decode_s)`  slot 0 record.
- `i_dec_dque_decode_1`  in  `$bits(decode_s)`  slot 1 record.
- `o_dque_dec_ready`  out  1  at least two free entries.
- `i_sch_dque_request`  in  1  schedule unit asks for up to two instructions.
- `o_dque_sch_ready`  out  1  queue non-empty.
- `o_dque_sch_ack`  out  1  registered; `o_dque_sch_decode_*` are valid this cycle.
- `o_dque_sch_decode_0`  out  `$bits(decode_s)`  oldest delivered record.
- `o_dque_sch_decode_1`  out  `$bits(decode_s)`  second-oldest record. `.valid=0` if only one was delivered.

## Operation
- **Storage:** circular buffer of `DEPTH` `decode_s` entries.
  - `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
- **Push** (only while `o_dque_dec_ready`=1):
  - Valid slots are written in order: slot 0 first, then slot 1.
  - If only `valid_1` is set, slot 1 is written at `wr_ptr`, so entries stay compacted.
  - `n_push` ∈ {0,1,2}.
  - The stored `.valid` bit is forced to 1.
  - Inputs arriving while ready=0 are ignored. The decoder must hold them.
- **Pop:** when `i_sch_dque_request`=1 and `count`≠0, `n_pop` = min(count, 2).
  - Entries at `rd_ptr` and `rd_ptr+1` are registered into `o_dque_sch_decode_0/1`.
  - `o_dque_sch_decode_1.valid`=0 when `n_pop`=1.
  - `o_dque_sch_ack` is set to 1 for one cycle.
- **Request with `count`=0:** no pop. Next cycle ack=0 and both output `.valid`=0.
- **Count update:** `count_next = count + n_push − n_pop`.
  - Push and pop in the same cycle are legal.
  - Pop uses only entries present before the edge; no same-cycle bypass.
- **Ready flags:**
  - `o_dque_dec_ready = (count ≤ DEPTH−2)`.
  - `o_dque_sch_ready = (count ≠ 0)`.
  - Both are combinational from registered `count` only.
- **Flush / reset:**
  - Pointers and `count` go to 0. Ack goes to 0. Both output `.valid` go to 0.
  - Flush and reset take priority over push and pop in the same cycle.
  - Storage contents are don't-care.
- **Output payload fields:**
  - When ack=0, the other fields hold their last value; only `.valid` is forced to 0.
  - Consumers must qualify with ack and `.valid`.

## Timing
- **Reset values:** `o_dque_dec_ready`=1, `o_dque_sch_ready`=0, `o_dque_sch_ack`=0, `o_dque_sch_decode_0/1.valid`=0.
- **Push to visible:** a record pushed at edge N raises `o_dque_sch_ready` after edge N. It can be popped by a request sampled at edge N+1 and appears on the outputs after edge N+1.
- **Request to ack:** 1 cycle. Request sampled at edge N gives ack and data high in the cycle after edge N.
- **Back-to-back requests:** sustain 2 instructions/cycle when `count` ≥ 2 every cycle.
- **Full boundary:** at `count`=DEPTH−1, ready=0 even though one entry is free. This guarantees that a 2-wide push never overflows.
- **Pointer wrap:** a pop or push spanning entry DEPTH−1→0 handles both entries correctly.
- **Flush mid-operation:** flush at edge N cancels any pop sampled at the same edge, so ack=0 next cycle. An ack already high in cycle N still completes.

## Test plan
- **Reset then request:** 3 cycles with `i_rst`=1, then request=1 on the empty queue. Required: dec_ready=1, sch_ready=0, ack stays 0, both `.valid`=0.
- **Push and pop pair:** push `rd_addr` 5 (slot 0) and 6 (slot 1) in one cycle, then request. Required: ack=1 after 1 cycle, `decode_0.rd_addr`=5, `decode_1.rd_addr`=6, both `.valid`=1, `count` returns to 0.
- **Single record:** push only slot 1 with `rd_addr`=9, then request. Required: `decode_0.rd_addr`=9, `decode_1.valid`=0.
- **Fill and wrap:** with DEPTH=8, push 2/cycle until dec_ready=0; this happens at count=7 after 4 cycles of pairs minus an odd single. Then pop 2/cycle while pushing 2/cycle for 10 cycles. Required: output `rd_addr` sequence matches push order exactly across the pointer wrap, with no loss or duplication.
- **Simultaneous push/pop at count=6:** push 2 and pop 2 in the same cycle. Required: count stays 6, dec_ready stays 1.
- **Flush mid-stream:** count=5, then flush together with request and push in the same cycle. Required: next cycle ack=0, count=0, sch_ready=0, dec_ready=1. The subsequent push of `rd_addr`=3 is the first record delivered.
